// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and load results into one regfile write port
// through an in-order FIFO, and exports a per-register pending-write mask.
module wb_arbiter #(
  parameter int DATA_WIDTH    = 16,
  parameter int REGADDR_WIDTH = 3,
  parameter int FIFO_DEPTH    = 4,
  parameter int DROP_R0       = 1,
  localparam int NUM_REGS     = 1 << REGADDR_WIDTH,
  localparam int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [REGADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0]    alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [REGADDR_WIDTH-1:0] mem_rd,
  input  logic [DATA_WIDTH-1:0]    mem_data,
  input  logic                     wb_stall,
  output logic                     reg_write,
  output logic [REGADDR_WIDTH-1:0] write_reg,
  output logic [DATA_WIDTH-1:0]    write_data,
  output logic [CNT_W-1:0]         fifo_count,
  output logic [NUM_REGS-1:0]      pending_mask
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [REGADDR_WIDTH-1:0] rd_mem_q   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]    data_mem_q [FIFO_DEPTH];

  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic                     reg_write_q, reg_write_d;
  logic [REGADDR_WIDTH-1:0] write_reg_q, write_reg_d;
  logic [DATA_WIDTH-1:0]    write_data_q, write_data_d;

  logic                     full, empty;
  logic                     mem_fire, alu_fire, accept, drop, push, pop;
  logic [REGADDR_WIDTH-1:0] push_rd;
  logic [DATA_WIDTH-1:0]    push_data;
  logic [PTR_W-1:0]         scan_idx;
  logic [NUM_REGS-1:0]      pending;

  assign full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty = (count_q == '0);

  // Ready looks only at occupancy, so a same-cycle pop never opens a slot for a push.
  assign mem_ready = !reset && !full;
  assign alu_ready = !reset && !full && !mem_valid;

  assign mem_fire  = mem_valid && mem_ready;
  assign alu_fire  = alu_valid && alu_ready;
  assign accept    = mem_fire || alu_fire;
  assign push_rd   = mem_fire ? mem_rd   : alu_rd;
  assign push_data = mem_fire ? mem_data : alu_data;
  assign drop      = (DROP_R0 != 0) && (push_rd == '0);
  assign push      = accept && !drop;
  assign pop       = !empty && !wb_stall;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d     = rd_ptr_q + PTR_W'(1);
      reg_write_d  = 1'b1;
      write_reg_d  = rd_mem_q[rd_ptr_q];
      write_data_d = data_mem_q[rd_ptr_q];
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

  // Storage needs no reset: occupancy is tracked solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem_q[wr_ptr_q]   <= push_rd;
      data_mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_comb begin
    pending  = '0;
    scan_idx = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      scan_idx = rd_ptr_q + PTR_W'(i);
      if (CNT_W'(i) < count_q) begin
        pending[rd_mem_q[scan_idx]] = 1'b1;
      end
    end
    if (reg_write_q) begin
      pending[write_reg_q] = 1'b1;
    end
    if (DROP_R0 != 0) begin
      pending[0] = 1'b0;
    end
  end

  assign reg_write    = reg_write_q;
  assign write_reg    = write_reg_q;
  assign write_data   = write_data_q;
  assign fifo_count   = count_q;
  assign pending_mask = pending;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, single commit, arbitration, backpressure,
// R0 drop, FIFO wrap and mid-run asynchronous reset.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, mem_valid, wb_stall;
  logic        alu_ready, mem_ready;
  logic [2:0]  alu_rd, mem_rd;
  logic [15:0] alu_data, mem_data;
  logic        reg_write;
  logic [2:0]  write_reg;
  logic [15:0] write_data;
  logic [2:0]  fifo_count;
  logic [7:0]  pending_mask;

  int passed = 0;
  int total  = 0;

  wb_arbiter dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_stall(wb_stall),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .fifo_count(fifo_count), .pending_mask(pending_mask)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed running, expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b1; alu_valid = 1'b0; mem_valid = 1'b0; wb_stall = 1'b0;
    alu_rd = '0; alu_data = '0; mem_rd = '0; mem_data = '0;
    settle();
    check("rst_alu_ready", alu_ready, 0);
    check("rst_mem_ready", mem_ready, 0);
    check("rst_count", fifo_count, 0);
    check("rst_reg_write", reg_write, 0);
    step(); step();
    reset = 1'b0;
    settle();
    check("rel_alu_ready", alu_ready, 1);
    check("rel_mem_ready", mem_ready, 1);
    check("rel_count", fifo_count, 0);
    check("rel_pending", pending_mask, 0);

    // Single ALU result, latency and pending window
    step();
    alu_valid = 1'b1; alu_rd = 3'd3; alu_data = 16'h3333;
    settle();
    check("t2_alu_ready", alu_ready, 1);
    step();
    alu_valid = 1'b0;
    settle();
    check("t2_count_n", fifo_count, 1);
    check("t2_regwr_n", reg_write, 0);
    check("t2_pend_n", pending_mask, 8'h08);
    step();
    check("t2_regwr_n1", reg_write, 1);
    check("t2_wreg_n1", write_reg, 3);
    check("t2_wdata_n1", write_data, 16'h3333);
    check("t2_count_n1", fifo_count, 0);
    check("t2_pend_n1", pending_mask, 8'h08);
    step();
    check("t2_regwr_n2", reg_write, 0);
    check("t2_pend_n2", pending_mask, 0);
    check("t2_hold_data", write_data, 16'h3333);

    // Simultaneous ALU and MEM offers: MEM wins
    alu_valid = 1'b1; alu_rd = 3'd1; alu_data = 16'h1111;
    mem_valid = 1'b1; mem_rd = 3'd2; mem_data = 16'h2222;
    settle();
    check("t3_alu_ready", alu_ready, 0);
    check("t3_mem_ready", mem_ready, 1);
    step();
    mem_valid = 1'b0;
    settle();
    check("t3_alu_ready2", alu_ready, 1);
    check("t3_count", fifo_count, 1);
    check("t3_pend_a", pending_mask, 8'h04);
    step();
    alu_valid = 1'b0;
    settle();
    check("t3_regwr_1", reg_write, 1);
    check("t3_wreg_1", write_reg, 2);
    check("t3_wdata_1", write_data, 16'h2222);
    check("t3_count_1", fifo_count, 1);
    check("t3_pend_b", pending_mask, 8'h06);
    step();
    check("t3_regwr_2", reg_write, 1);
    check("t3_wreg_2", write_reg, 1);
    check("t3_wdata_2", write_data, 16'h1111);
    check("t3_count_2", fifo_count, 0);
    check("t3_pend_c", pending_mask, 8'h02);
    step();
    check("t3_regwr_3", reg_write, 0);
    check("t3_pend_d", pending_mask, 0);

    // Stall: fill FIFO, backpressure, then drain in order
    wb_stall = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      alu_valid = 1'b1; alu_rd = 3'(k); alu_data = 16'hA000 + 16'(k);
      settle();
      check("t4_fill_ready", alu_ready, 1);
      step();
    end
    alu_rd = 3'd5; alu_data = 16'hA005;
    settle();
    check("t4_full_count", fifo_count, 4);
    check("t4_full_alu_ready", alu_ready, 0);
    check("t4_full_mem_ready", mem_ready, 0);
    check("t4_full_pend", pending_mask, 8'h1E);
    check("t4_full_regwr", reg_write, 0);
    step();
    check("t4_stall_count", fifo_count, 4);
    check("t4_stall_regwr", reg_write, 0);
    wb_stall = 1'b0;
    settle();
    check("t4_full_nopush", alu_ready, 0);
    step();
    check("t4_c1_regwr", reg_write, 1);
    check("t4_c1_wreg", write_reg, 1);
    check("t4_c1_wdata", write_data, 16'hA001);
    check("t4_c1_count", fifo_count, 3);
    check("t4_c1_ready", alu_ready, 1);
    step();
    alu_valid = 1'b0;
    check("t4_c2_wreg", write_reg, 2);
    check("t4_c2_wdata", write_data, 16'hA002);
    check("t4_c2_count", fifo_count, 3);
    step();
    check("t4_c3_wreg", write_reg, 3);
    check("t4_c3_count", fifo_count, 2);
    step();
    check("t4_c4_wreg", write_reg, 4);
    check("t4_c4_count", fifo_count, 1);
    step();
    check("t4_c5_regwr", reg_write, 1);
    check("t4_c5_wreg", write_reg, 5);
    check("t4_c5_wdata", write_data, 16'hA005);
    check("t4_c5_count", fifo_count, 0);
    step();
    check("t4_done_regwr", reg_write, 0);

    // Load to R0 is accepted and discarded
    mem_valid = 1'b1; mem_rd = 3'd0; mem_data = 16'hFFFF;
    settle();
    check("t5_mem_ready", mem_ready, 1);
    step();
    mem_valid = 1'b0;
    settle();
    check("t5_count", fifo_count, 0);
    check("t5_pend", pending_mask, 0);
    check("t5_regwr_a", reg_write, 0);
    step();
    check("t5_regwr_b", reg_write, 0);
    check("t5_wdata_hold", write_data, 16'hA005);

    // Streaming push/pop every cycle across pointer wrap
    for (int i = 0; i < 9; i++) begin
      alu_valid = 1'b1; alu_rd = 3'((i % 7) + 1); alu_data = 16'hB000 + 16'(i);
      settle();
      check("t6_ready", alu_ready, 1);
      step();
      check("t6_count", fifo_count, 1);
      if (i > 0) begin
        check("t6_regwr", reg_write, 1);
        check("t6_wreg", write_reg, 32'(((i - 1) % 7) + 1));
        check("t6_wdata", write_data, 32'(16'hB000 + 16'(i - 1)));
      end
    end
    alu_valid = 1'b0;
    step();
    check("t6_last_regwr", reg_write, 1);
    check("t6_last_wdata", write_data, 16'hB008);
    check("t6_last_count", fifo_count, 0);
    step();
    check("t6_idle_regwr", reg_write, 0);

    // Asynchronous reset mid-run with traffic in flight
    alu_valid = 1'b1; alu_rd = 3'd6; alu_data = 16'hC006;
    step();
    alu_rd = 3'd7; alu_data = 16'hC007;
    step();
    alu_valid = 1'b1; mem_valid = 1'b1; mem_rd = 3'd4; mem_data = 16'hC004;
    settle();
    check("t1_pre_regwr", reg_write, 1);
    check("t1_pre_count", fifo_count, 1);
    reset = 1'b1;
    settle();
    check("t1_regwr", reg_write, 0);
    check("t1_wreg", write_reg, 0);
    check("t1_wdata", write_data, 0);
    check("t1_count", fifo_count, 0);
    check("t1_pend", pending_mask, 0);
    check("t1_alu_ready", alu_ready, 0);
    check("t1_mem_ready", mem_ready, 0);
    step();
    alu_valid = 1'b0; mem_valid = 1'b0;
    reset = 1'b0;
    settle();
    check("t1_rel_ready", mem_ready, 1);
    check("t1_rel_count", fifo_count, 0);
    step();
    check("t1_discard_regwr", reg_write, 0);
    check("t1_discard_count", fifo_count, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
